serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operands a, b, cin valid this cycle.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  first operand, unsigned.
REQ-007 b  input  WIDTH  second operand, unsigned.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  sum and cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 sum  output  WIDTH  result bits, (a+b+cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL add bit-serially, LSB first, one bit per clock, with the bit sum and carry produced by exactly one full_adder instance.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE and SHALL depend on state only.
REQ-016 In IDLE with in_valid=1, the block SHALL register a, b and cin into a_reg, b_reg and carry, clear bit counter cnt and sum_reg, and go to RUN.
REQ-017 In any state other than IDLE, in_valid SHALL be ignored.
REQ-018 Each RUN cycle SHALL:
- feed a_reg[0], b_reg[0] and carry to the full_adder;
- shift its sum output into sum_reg MSB, with sum_reg shifting right;
- shift a_reg and b_reg right by one;
- load carry from the full_adder carry output;
- increment cnt.
REQ-019 When cnt==WIDTH-1 in RUN, the block SHALL perform the final bit step and go to DONE.
REQ-020 The RUN phase SHALL last exactly WIDTH cycles, so out_valid asserts WIDTH cycles after the accepting edge.
REQ-021 In DONE, out_valid SHALL be 1, sum SHALL equal sum_reg, cout SHALL equal carry, and both SHALL stay stable until accepted.
REQ-022 In DONE with out_ready=1, the block SHALL return to IDLE on that edge.
REQ-023 A new operand SHALL not be accepted in the same cycle a result is accepted; minimum issue interval is WIDTH+2 cycles.
REQ-024 out_ready held low SHALL keep the block in DONE indefinitely with outputs unchanged.
REQ-025 Outside DONE, out_valid SHALL be 0.
REQ-026 Outside DONE, sum and cout SHALL hold their last registered values (0 after reset).
REQ-027 cnt SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during RUN.
REQ-028 Edge cases SHALL be exact: all-ones + all-ones + cin=1 gives sum all-ones, cout=1; 0+0+0 gives sum 0, cout=0.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force:
- state to IDLE;
- a_reg, b_reg, sum_reg, carry, cnt, sum, cout and out_valid to 0;
- in_ready to 1.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation with no result produced.
REQ-031 After rst_n deasserts, the block SHALL accept operands on the first rising edge where in_valid=1.

Verification (WIDTH=8)
REQ-032 a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid=1 exactly 8 cycles after accept, sum=0x00, cout=1.
REQ-033 a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 a=0x5A, b=0x3C, cin=0, out_ready=0 for 5 cycles after out_valid -> sum=0x96, cout=0 held stable, in_ready=0 throughout, return to IDLE on the edge out_ready rises.
REQ-035 rst_n pulsed low at RUN cycle 4 -> outputs 0 asynchronously, in_ready=1, no out_valid; next operands 0x10+0x20 -> sum=0x30.
REQ-036 in_valid held high with out_ready=1 for 3 operand pairs -> accepts spaced exactly 10 cycles apart; in_valid pulses during RUN/DONE ignored; results match a reference sum.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (ready only in IDLE)
//   a, b, cin            - unsigned operands and carry-in
//   out_valid / out_ready- result handshake (valid only in DONE)
//   sum, cout            - (a+b+cin) mod 2^WIDTH and final carry, held until next result

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum, r_sum_out;
    logic             r_carry, r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_c, w_last;

    assign w_last = r_cnt == CW'(WIDTH - 1);

    full_adder u_fa (
        .i_a(r_a[0]),
        .i_b(r_b[0]),
        .i_c(r_carry),
        .o_s(w_s),
        .o_c(w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && in_valid)      w_next = RUN;
        else if (r_state == RUN && w_last)    w_next = DONE;
        else if (r_state == DONE && out_ready) w_next = IDLE;
    end

    // The visible result lives in its own registers, loaded on the final bit
    // step, so sum/cout stay frozen while the next operation is shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_cout    <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum_out <= {w_s, r_sum[WIDTH-1:1]};
                r_cout    <= w_c;
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign sum       = r_sum_out;
    assign cout      = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder against an arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] sum;
    int           n_chk = 0, n_pass = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int hold);
        int n;
        logic [W:0] exp;
        exp = ref_add(ta, tb, tc);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", in_ready, 1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 4 * W) begin
            chk("run_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("latency", n, W);
        chk("sum", sum, exp[W-1:0]);
        chk("cout", cout, exp[W]);
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_result", {cout, sum}, exp);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ret_idle", {in_ready, out_valid}, 2'b10);
        chk("keep_result", {cout, sum}, exp);
    endtask

    initial begin
        logic [W:0] exp_q[$];
        int         acc[$];
        int         cyc, n_res;
        #2 rst_n = 1'b0;
        #1 chk("rst_state", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, {W{1'b0}}});
        @(negedge clk);
        rst_n = 1'b1;

        op(8'hFF, 8'h01, 1'b0, 0);
        op(8'h00, 8'h00, 1'b1, 1);
        op(8'hFF, 8'hFF, 1'b1, 0);
        op(8'h00, 8'h00, 1'b0, 0);
        op(8'h5A, 8'h3C, 1'b0, 5);
        for (int i = 0; i < 15; i++)
            op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
        op(8'hFF, 8'hFF, 1'b1, 0);

        // abort mid-RUN
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, {W{1'b0}}});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_result", out_valid, 0);
        end
        op(8'h10, 8'h20, 1'b0, 0);

        // back-to-back with in_valid held high
        out_ready = 1'b1;
        cyc = 0;
        n_res = 0;
        while (n_res < 3 && cyc < 80) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            in_valid = acc.size() < 3;
            if (in_ready && in_valid) begin
                exp_q.push_back(ref_add(a, b, cin));
                acc.push_back(cyc);
            end
            if (out_valid) begin
                chk("b2b_result", {cout, sum}, exp_q.size() > 0 ? exp_q.pop_front() : '1);
                n_res++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_count", n_res, 3);
        chk("b2b_accepts", acc.size(), 3);
        for (int i = 1; i < acc.size(); i++) chk("b2b_gap", acc[i] - acc[i-1], W + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
